pe_stu_upstream_tx: RTL

//  PE-side transmitter for the upstream stack bus (pe__stu__*). Takes a per-packet descriptor from
//  the streamingOps controller plus result words from the streaming-op datapath, frames them into
//  SOM/MOM/EOM (or SOM_EOM) beats and drives them to the stack upstream unit under valid/ready.

---
 rtl/stack_up_tx_pkg.sv | 42 ++++
 rtl/pe_stu_tx_fifo.sv | 61 ++++++
 rtl/pe_stu_upstream_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stack_up_tx_pkg.sv
// Shared definitions for the PE-side upstream stack transmitter: interface widths,
// beat framing codes, FSM states and the latched packet descriptor.
package stack_up_tx_pkg;

    localparam int STACK_UP_INTF_DATA     = 64;
    localparam int STACK_UP_INTF_TYPE     = 2;
    localparam int STACK_UP_INTF_OOB_DATA = 32;
    localparam int STACK_UP_DESC_LEN_W    = 8;

    typedef enum logic [1:0] {
        CNTL_MOM     = 2'b00,
        CNTL_SOM     = 2'b01,
        CNTL_EOM     = 2'b10,
        CNTL_SOM_EOM = 2'b11
    } cntl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [STACK_UP_INTF_TYPE-1:0]     ptype;
        logic [STACK_UP_INTF_OOB_DATA-1:0] oob;
        logic [STACK_UP_DESC_LEN_W-1:0]    len;
    } desc_t;

    function automatic cntl_e frame_cntl(input logic first, input logic last);
        cntl_e c;
        if (first && last) begin
            c = CNTL_SOM_EOM;
        end else if (first) begin
            c = CNTL_SOM;
        end else if (last) begin
            c = CNTL_EOM;
        end else begin
            c = CNTL_MOM;
        end
        return c;
    endfunction

endpackage

// File: rtl/pe_stu_tx_fifo.sv
// Synchronous result-word FIFO with a registered occupancy count; the head word is
// always presented so the output register can load it in the same cycle it pops.
module pe_stu_tx_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pe_stu_upstream_tx.sv
// PE-side upstream stack transmitter: frames queued result words into SOM/MOM/EOM beats
// under a per-packet descriptor and drives them out through a single output register.
module pe_stu_upstream_tx
    import stack_up_tx_pkg::*;
#(
    parameter int DATA_W = STACK_UP_INTF_DATA,
    parameter int TYPE_W = STACK_UP_INTF_TYPE,
    parameter int OOB_W  = STACK_UP_INTF_OOB_DATA,
    parameter int LEN_W  = STACK_UP_DESC_LEN_W,
    parameter int FIFO_D = 8
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              cntl__stu__desc_valid,
    output logic              stu__cntl__desc_ready,
    input  logic [TYPE_W-1:0] cntl__stu__desc_type,
    input  logic [OOB_W-1:0]  cntl__stu__desc_oob,
    input  logic [LEN_W-1:0]  cntl__stu__desc_len,
    input  logic              strm__stu__valid,
    output logic              stu__strm__ready,
    input  logic [DATA_W-1:0] strm__stu__data,
    output logic              pe__stu__valid,
    output logic [1:0]        pe__stu__cntl,
    output logic [TYPE_W-1:0] pe__stu__type,
    output logic [DATA_W-1:0] pe__stu__data,
    output logic [OOB_W-1:0]  pe__stu__oob_data,
    input  logic              stu__pe__ready,
    output logic              stu__cntl__err_len0
);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    state_e            state_q;
    logic              desc_ready_q;
    desc_t             desc_q;
    logic              first_q;
    logic              err_len0_q;
    logic              valid_q;
    logic [1:0]        cntl_q;
    logic [TYPE_W-1:0] type_q;
    logic [DATA_W-1:0] data_q;
    logic [OOB_W-1:0]  oob_q;

    logic              desc_fire;
    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  cur_len;
    logic              cur_first;
    logic              cur_last;
    logic [TYPE_W-1:0] cur_type;
    logic [OOB_W-1:0]  cur_oob;
    logic              pkt_open;
    logic              load;

    assign fifo_push = strm__stu__valid && !fifo_full;
    assign fifo_pop  = load;

    pe_stu_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_D)
    ) u_fifo (
        .clk         (clk),
        .srst        (reset_poweron),
        .push_i      (fifo_push),
        .push_data_i (strm__stu__data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A descriptor accepted this cycle is usable immediately, so a queued word can be
    // loaded without first passing through the latched descriptor.
    always_comb begin
        desc_fire = cntl__stu__desc_valid && desc_ready_q;
        len_eff   = (cntl__stu__desc_len == '0) ? LEN_W'(1) : cntl__stu__desc_len;
        cur_len   = desc_fire ? len_eff : desc_q.len;
        cur_first = desc_fire ? 1'b1 : first_q;
        cur_type  = desc_fire ? cntl__stu__desc_type : desc_q.ptype;
        cur_oob   = desc_fire ? cntl__stu__desc_oob : desc_q.oob;
        cur_last  = (cur_len == LEN_W'(1));
        pkt_open  = desc_fire || (state_q == ST_SEND);
        load      = pkt_open && (!valid_q || stu__pe__ready) && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q      <= ST_IDLE;
            desc_ready_q <= 1'b0;
            desc_q       <= '0;
            first_q      <= 1'b0;
            err_len0_q   <= 1'b0;
            valid_q      <= 1'b0;
            cntl_q       <= '0;
            type_q       <= '0;
            data_q       <= '0;
            oob_q        <= '0;
        end else begin
            if (state_q == ST_IDLE && !desc_fire) begin
                desc_ready_q <= 1'b1;
            end

            if (desc_fire) begin
                desc_q.ptype <= cntl__stu__desc_type;
                desc_q.oob   <= cntl__stu__desc_oob;
                desc_q.len   <= len_eff;
                first_q      <= 1'b1;
                state_q      <= ST_SEND;
                desc_ready_q <= 1'b0;
                if (cntl__stu__desc_len == '0) begin
                    err_len0_q <= 1'b1;
                end
            end

            // The last beat closes the packet here, overriding the descriptor accept above
            // when a single-beat packet is accepted and loaded in the same cycle.
            if (load) begin
                valid_q    <= 1'b1;
                cntl_q     <= frame_cntl(cur_first, cur_last);
                type_q     <= cur_type;
                data_q     <= fifo_head;
                oob_q      <= cur_oob;
                desc_q.len <= cur_len - 1'b1;
                first_q    <= 1'b0;
                if (cur_last) begin
                    state_q      <= ST_IDLE;
                    desc_ready_q <= 1'b1;
                end
            end else if (valid_q && stu__pe__ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign stu__cntl__desc_ready = desc_ready_q;
    assign stu__strm__ready      = !fifo_full;
    assign pe__stu__valid        = valid_q;
    assign pe__stu__cntl         = cntl_q;
    assign pe__stu__type         = type_q;
    assign pe__stu__data         = data_q;
    assign pe__stu__oob_data     = oob_q;
    assign stu__cntl__err_len0   = err_len0_q;

endmodule
